// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Loads a configuration chain (ccff) from a host word stream. Each accepted
//   word is shifted MSB-first onto ccff_head. ccff_shift_en gates the chain
//   clock and is high only during shift cycles, so host stalls never move the
//   chain. A pass ends after CHAIN_LEN shifts. Any low-order bits of the final
//   word that lie beyond CHAIN_LEN are dropped.
//
// Optional feature, macro CCFF_LOADER_VERIFY_EN:
//   When defined, a pass started with verify=1 also compares ccff_tail with
//   ccff_head in every shift cycle and sets a sticky error flag on mismatch.
//   When undefined, verify and ccff_tail are ignored and error is tied to 0.
//
// Ports:
//   prog_clk       clock; all state changes on its rising edge
//   pReset_n       synchronous active-low reset
//   start          one-cycle pass request, honoured only when idle
//   verify         sampled with start; selects a verify pass
//   bs_data        host configuration word (WORD_W bits)
//   bs_valid       host word valid
//   bs_ready       loader accepts a word this cycle
//   ccff_head      serial data to the chain head
//   ccff_shift_en  chain shifts at the end of every cycle this is high
//   ccff_tail      serial data returned from the chain tail
//   busy           pass in progress
//   done           one-cycle pulse at the end of a pass
//   error          sticky verify mismatch, cleared when a pass starts
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int WIW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [WORD_W-1:0] word_q;
  logic [WIW-1:0]    widx_q;
  logic [BCW-1:0]    bcnt_q;
  logic              ready_q;
  logic              head_q;
  logic              shen_q;
  logic              busy_q;
  logic              done_q;

  logic [WORD_W-1:0] word_shl;
  logic [WIW-1:0]    widx_inc;
  logic [BCW-1:0]    bcnt_inc;

  assign word_shl = word_q << 1;
  assign widx_inc = widx_q + WIW'(1);
  assign bcnt_inc = bcnt_q + BCW'(1);

`ifdef CCFF_LOADER_VERIFY_EN
  logic verify_q;
  logic error_q;
  assign error = error_q;
`else
  logic unused_inputs;
  assign unused_inputs = verify ^ ccff_tail;
  assign error         = 1'b0;
`endif

  // head_q is loaded one cycle ahead with the bit that will be on the wire
  // in the next shift cycle, keeping ccff_head a registered output.
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      ready_q <= 1'b0;
      head_q  <= 1'b0;
      shen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
      verify_q <= 1'b0;
      error_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            bcnt_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
`ifdef CCFF_LOADER_VERIFY_EN
            verify_q <= verify;
            error_q  <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (bs_valid && ready_q) begin
            state_q <= S_SHIFT;
            word_q  <= bs_data;
            widx_q  <= '0;
            ready_q <= 1'b0;
            shen_q  <= 1'b1;
            head_q  <= bs_data[WORD_W-1];
          end
        end
        S_SHIFT: begin
          word_q <= word_shl;
          widx_q <= widx_inc;
          bcnt_q <= bcnt_inc;
`ifdef CCFF_LOADER_VERIFY_EN
          if (verify_q && (ccff_tail != head_q)) begin
            error_q <= 1'b1;
          end
`endif
          if (bcnt_inc == BCW'(CHAIN_LEN)) begin
            state_q <= S_DONE;
            shen_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (widx_inc == WIW'(WORD_W)) begin
            state_q <= S_FETCH;
            shen_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            head_q <= word_shl[WORD_W-1];
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bs_ready      = ready_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shen_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
